// File: rtl/mouse_cmd_scheduler.sv
// Shares one PS/2 transmitter between two command requesters: arbitrates, sends,
// waits for the device acknowledge, resends on 0xFE, and forwards other receive bytes.
module mouse_cmd_scheduler #(
   parameter int ACK_TIMEOUT = 500000,
   parameter int MAX_RETRY   = 3,
   parameter int CNT_W       = 19
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       REQ0_VALID,
   input  logic [7:0] REQ0_BYTE,
   output logic       REQ0_GRANT,
   output logic       REQ0_DONE,
   input  logic       REQ1_VALID,
   input  logic [7:0] REQ1_BYTE,
   output logic       REQ1_GRANT,
   output logic       REQ1_DONE,
   output logic [1:0] DONE_STATUS,
   output logic       BUSY,
   output logic       SEND_BYTE,
   output logic [7:0] BYTE_TO_SEND,
   input  logic       BYTE_SENT,
   input  logic       BYTE_READY,
   input  logic [7:0] BYTE_READ,
   input  logic [1:0] BYTE_ERROR_CODE,
   output logic       RX_PASS_VALID,
   output logic [7:0] RX_PASS_BYTE
);
   localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
   localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(ACK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] TIMER_MAX  = '1;
   localparam logic [RTY_W-1:0] RETRY_MAX  = RTY_W'(MAX_RETRY);

   typedef enum logic [1:0] {IDLE, WAIT_TX, WAIT_ACK, DONE} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic [RTY_W-1:0] retry_q, retry_d;
   logic             owner_q, owner_d;
   logic             last_q, last_d;
   logic [7:0]       byte_q, byte_d;
   logic             grant0_q, grant0_d, grant1_q, grant1_d;
   logic             send_q, send_d;
   logic             done0_q, done0_d, done1_q, done1_d;
   logic [1:0]       status_q, status_d;
   logic             busy_q;
   logic             rx_valid_q;
   logic [7:0]       rx_byte_q;
   logic             pick;
   logic             timer_exp;
   logic             finish;
   logic             rx_forward;

   // On a tie the port that did not win last time is chosen.
   assign pick       = REQ1_VALID & (~REQ0_VALID | ~last_q);
   assign timer_exp  = (timer_q == TIMER_LAST);
   assign rx_forward = BYTE_READY & (state_q != WAIT_ACK);

   always_comb begin
      state_d  = state_q;
      timer_d  = (timer_q == TIMER_MAX) ? timer_q : timer_q + 1'b1;
      retry_d  = retry_q;
      owner_d  = owner_q;
      last_d   = last_q;
      byte_d   = byte_q;
      grant0_d = 1'b0;
      grant1_d = 1'b0;
      send_d   = 1'b0;
      done0_d  = 1'b0;
      done1_d  = 1'b0;
      status_d = status_q;
      finish   = 1'b0;
      case (state_q)
         IDLE: begin
            if (REQ0_VALID | REQ1_VALID) begin
               owner_d  = pick;
               last_d   = pick;
               byte_d   = pick ? REQ1_BYTE : REQ0_BYTE;
               grant0_d = ~pick;
               grant1_d = pick;
               send_d   = 1'b1;
               retry_d  = '0;
               timer_d  = '0;
               state_d  = WAIT_TX;
            end
         end
         WAIT_TX: begin
            if (BYTE_SENT) begin
               timer_d = '0;
               state_d = WAIT_ACK;
            end else if (timer_exp) begin
               finish   = 1'b1;
               status_d = 2'b10;
            end
         end
         WAIT_ACK: begin
            // A byte arriving on the expiry cycle wins over the timeout.
            if (BYTE_READY) begin
               if (BYTE_ERROR_CODE != 2'b00) begin
                  finish   = 1'b1;
                  status_d = 2'b11;
               end else if (BYTE_READ == 8'hFA) begin
                  finish   = 1'b1;
                  status_d = 2'b00;
               end else if (BYTE_READ == 8'hFE) begin
                  if (retry_q < RETRY_MAX) begin
                     retry_d = retry_q + 1'b1;
                     timer_d = '0;
                     send_d  = 1'b1;
                     state_d = WAIT_TX;
                  end else begin
                     finish   = 1'b1;
                     status_d = 2'b01;
                  end
               end else begin
                  finish   = 1'b1;
                  status_d = 2'b11;
               end
            end else if (timer_exp) begin
               finish   = 1'b1;
               status_d = 2'b10;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (finish) begin
         done0_d = ~owner_q;
         done1_d = owner_q;
         state_d = DONE;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q    <= IDLE;
         timer_q    <= '0;
         retry_q    <= '0;
         owner_q    <= 1'b0;
         last_q     <= 1'b1;
         byte_q     <= 8'hFF;
         grant0_q   <= 1'b0;
         grant1_q   <= 1'b0;
         send_q     <= 1'b0;
         done0_q    <= 1'b0;
         done1_q    <= 1'b0;
         status_q   <= 2'b00;
         busy_q     <= 1'b0;
         rx_valid_q <= 1'b0;
         rx_byte_q  <= 8'h00;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         retry_q    <= retry_d;
         owner_q    <= owner_d;
         last_q     <= last_d;
         byte_q     <= byte_d;
         grant0_q   <= grant0_d;
         grant1_q   <= grant1_d;
         send_q     <= send_d;
         done0_q    <= done0_d;
         done1_q    <= done1_d;
         status_q   <= status_d;
         busy_q     <= (state_d != IDLE);
         rx_valid_q <= rx_forward;
         if (rx_forward) begin
            rx_byte_q <= BYTE_READ;
         end
      end
   end

   assign REQ0_GRANT    = grant0_q;
   assign REQ1_GRANT    = grant1_q;
   assign REQ0_DONE     = done0_q;
   assign REQ1_DONE     = done1_q;
   assign DONE_STATUS   = status_q;
   assign BUSY          = busy_q;
   assign SEND_BYTE     = send_q;
   assign BYTE_TO_SEND  = byte_q;
   assign RX_PASS_VALID = rx_valid_q;
   assign RX_PASS_BYTE  = rx_byte_q;
endmodule

// File: tb/tb_mouse_cmd_scheduler.sv
// Self-checking bench for mouse_cmd_scheduler: directed scenarios plus randomized
// commands, checked against a transaction-level model of arbitration and ack outcomes.
module tb_mouse_cmd_scheduler;
   localparam int ACK_TO = 40;
   localparam int MAX_R  = 3;

   logic       CLK = 1'b0;
   logic       RESET;
   logic       REQ0_VALID, REQ1_VALID;
   logic [7:0] REQ0_BYTE, REQ1_BYTE;
   logic       REQ0_GRANT, REQ1_GRANT, REQ0_DONE, REQ1_DONE;
   logic [1:0] DONE_STATUS;
   logic       BUSY, SEND_BYTE;
   logic [7:0] BYTE_TO_SEND;
   logic       BYTE_SENT, BYTE_READY;
   logic [7:0] BYTE_READ;
   logic [1:0] BYTE_ERROR_CODE;
   logic       RX_PASS_VALID;
   logic [7:0] RX_PASS_BYTE;

   mouse_cmd_scheduler #(.ACK_TIMEOUT(ACK_TO), .MAX_RETRY(MAX_R), .CNT_W(19)) dut (
      .CLK(CLK), .RESET(RESET),
      .REQ0_VALID(REQ0_VALID), .REQ0_BYTE(REQ0_BYTE), .REQ0_GRANT(REQ0_GRANT), .REQ0_DONE(REQ0_DONE),
      .REQ1_VALID(REQ1_VALID), .REQ1_BYTE(REQ1_BYTE), .REQ1_GRANT(REQ1_GRANT), .REQ1_DONE(REQ1_DONE),
      .DONE_STATUS(DONE_STATUS), .BUSY(BUSY), .SEND_BYTE(SEND_BYTE), .BYTE_TO_SEND(BYTE_TO_SEND),
      .BYTE_SENT(BYTE_SENT), .BYTE_READY(BYTE_READY), .BYTE_READ(BYTE_READ),
      .BYTE_ERROR_CODE(BYTE_ERROR_CODE), .RX_PASS_VALID(RX_PASS_VALID), .RX_PASS_BYTE(RX_PASS_BYTE)
   );

   always #5 CLK = ~CLK;

   int n_tests = 0;
   int n_fail  = 0;

   // Event log written only by the monitor.
   int         cyc = 0;
   int         send_cnt = 0, grant_cnt = 0, done_cnt = 0;
   int         last_send_cyc = 0, grant_cyc = 0, done_cyc = 0;
   int         grant_port = 0, done_port = 0;
   logic [7:0] last_send_byte = 8'h00;
   logic [1:0] done_status = 2'b00;
   logic [7:0] rx_bytes[$];
   int         rx_cycs[$];

   always @(posedge CLK) begin
      #1;
      cyc++;
      if (SEND_BYTE) begin
         send_cnt++;
         last_send_byte = BYTE_TO_SEND;
         last_send_cyc  = cyc;
      end
      if (REQ0_GRANT || REQ1_GRANT) begin
         grant_cnt++;
         grant_port = REQ1_GRANT ? 1 : 0;
         grant_cyc  = cyc;
      end
      if (REQ0_DONE || REQ1_DONE) begin
         done_cnt++;
         done_port   = REQ1_DONE ? 1 : 0;
         done_status = DONE_STATUS;
         done_cyc    = cyc;
      end
      if (RX_PASS_VALID) begin
         rx_bytes.push_back(RX_PASS_BYTE);
         rx_cycs.push_back(cyc);
      end
   end

   int model_last = 1;   // port that won the most recent arbitration
   int rx_rd = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("[TB] ok %s = %0h", tag, got);
      end
   endtask

   task automatic pulse_sent();
      BYTE_SENT = 1'b1;
      @(negedge CLK);
      BYTE_SENT = 1'b0;
   endtask

   task automatic pulse_rx(input logic [7:0] b, input logic [1:0] err);
      BYTE_READY = 1'b1; BYTE_READ = b; BYTE_ERROR_CODE = err;
      @(negedge CLK);
      BYTE_READY = 1'b0; BYTE_ERROR_CODE = 2'b00;
   endtask

   task automatic wait_grant(input int g0, input int exp_port);
      int t = 0;
      while (grant_cnt == g0 && t < 20) begin
         @(negedge CLK);
         t++;
      end
      check_val("grant_seen", grant_cnt, g0 + 1);
      check_val("grant_port", grant_port, exp_port);
      model_last = exp_port;
   endtask

   // kind: 0 ack, 1 no response, 2 rx error, 3 junk byte, 4 no BYTE_SENT, 5 ack on expiry cycle
   task automatic serve(input int port, input logic [7:0] b, input int nfe, input int kind, input int tx_dly);
      int         base_send, dbase, handled, t, sent_cyc, exp_sends;
      logic [1:0] exp_st;
      logic [7:0] rb;
      if (nfe > MAX_R) begin
         exp_st = 2'b01; exp_sends = MAX_R + 1;
      end else begin
         exp_sends = nfe + 1;
         case (kind)
            0, 5:    exp_st = 2'b00;
            1, 4:    exp_st = 2'b10;
            default: exp_st = 2'b11;
         endcase
      end
      base_send = send_cnt - 1;
      dbase     = done_cnt;
      handled   = 0;
      sent_cyc  = 0;
      check_val("busy_in_cmd", BUSY, 1);
      while (done_cnt == dbase) begin
         t = 0;
         while (send_cnt == base_send + handled && done_cnt == dbase && t < 4 * ACK_TO) begin
            @(negedge CLK);
            t++;
         end
         if (done_cnt != dbase) break;
         if (t >= 4 * ACK_TO) begin
            check_val("event_wait", send_cnt, base_send + handled + 1);
            break;
         end
         handled++;
         check_val("tx_byte", last_send_byte, b);
         if (kind == 4 && nfe <= MAX_R && handled == nfe + 1) continue;
         repeat (tx_dly) @(negedge CLK);
         sent_cyc = cyc + 1;
         pulse_sent();
         if (handled <= nfe) begin
            repeat ($urandom_range(0, 8)) @(negedge CLK);
            pulse_rx(8'hFE, 2'b00);
         end else begin
            case (kind)
               0: begin
                  repeat ($urandom_range(0, 8)) @(negedge CLK);
                  pulse_rx(8'hFA, 2'b00);
               end
               2: begin
                  repeat ($urandom_range(0, 8)) @(negedge CLK);
                  pulse_rx(8'($urandom), 2'($urandom_range(1, 3)));
               end
               3: begin
                  rb = 8'($urandom);
                  while (rb == 8'hFA || rb == 8'hFE) rb = 8'($urandom);
                  repeat ($urandom_range(0, 8)) @(negedge CLK);
                  pulse_rx(rb, 2'b00);
               end
               5: begin
                  while (cyc < sent_cyc + ACK_TO - 1) @(negedge CLK);
                  pulse_rx(8'hFA, 2'b00);
               end
               default: ;
            endcase
         end
      end
      check_val("done_port", done_port, port);
      check_val("done_status", done_status, exp_st);
      check_val("n_sends", send_cnt - base_send, exp_sends);
      if (nfe <= MAX_R && (kind == 1 || kind == 5))
         check_val("ack_wait_cycle", done_cyc, sent_cyc + ACK_TO);
      if (nfe <= MAX_R && kind == 4)
         check_val("tx_wait_cycle", done_cyc, last_send_cyc + ACK_TO);
   endtask

   task automatic run_cmd(input int port, input logic [7:0] b, input int nfe, input int kind, input int tx_dly);
      int g0, s;
      g0 = grant_cnt;
      @(negedge CLK);
      if (port == 0) begin REQ0_VALID = 1'b1; REQ0_BYTE = b; end
      else begin REQ1_VALID = 1'b1; REQ1_BYTE = b; end
      wait_grant(g0, port);
      REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
      serve(port, b, nfe, kind, tx_dly);
      @(negedge CLK);
      check_val("busy_after_done", BUSY, 0);
      s = send_cnt;
      repeat (5) @(negedge CLK);
      check_val("no_extra_send", send_cnt, s);
      check_val("ack_not_forwarded", rx_bytes.size(), rx_rd);
   endtask

   logic [7:0] pt_byte[3];
   logic [1:0] pt_err[3];
   int         pt_cyc[3];
   int         g0, d0, s0, p;

   initial begin
      RESET = 1'b1; REQ0_VALID = 1'b0; REQ1_VALID = 1'b0; REQ0_BYTE = 8'h00; REQ1_BYTE = 8'h00;
      BYTE_SENT = 1'b0; BYTE_READY = 1'b0; BYTE_READ = 8'h00; BYTE_ERROR_CODE = 2'b00;
      repeat (3) @(negedge CLK);
      check_val("rst_busy", BUSY, 0);
      check_val("rst_send", SEND_BYTE, 0);
      check_val("rst_tx_byte", BYTE_TO_SEND, 8'hFF);
      check_val("rst_status", DONE_STATUS, 2'b00);
      check_val("rst_rx_byte", RX_PASS_BYTE, 8'h00);
      RESET = 1'b0;

      // Both raised at once: port 0 first, then port 1 two cycles after DONE, then port 0 again.
      for (int rep = 0; rep < 2; rep++) begin
         g0 = grant_cnt;
         @(negedge CLK);
         REQ0_VALID = 1'b1; REQ0_BYTE = 8'hF4; REQ1_VALID = 1'b1; REQ1_BYTE = 8'hEA;
         p = 1 - model_last;
         wait_grant(g0, p);
         if (p == 0) REQ0_VALID = 1'b0; else REQ1_VALID = 1'b0;
         serve(p, (p == 0) ? 8'hF4 : 8'hEA, 0, 0, 2);
         g0 = grant_cnt;
         wait_grant(g0, 1 - p);
         check_val("rr_gap", grant_cyc, done_cyc + 2);
         REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
         serve(1 - p, (p == 0) ? 8'hEA : 8'hF4, 0, 0, 1);
         repeat (3) @(negedge CLK);
      end

      run_cmd(0, 8'hFF, 0, 0, 20);   // plain ack after a slow transmit
      run_cmd(0, 8'hFF, 0, 1, 3);    // ack timeout
      run_cmd(0, 8'hFF, 0, 5, 3);    // ack on the expiry cycle

      for (int i = 0; i < 24; i++) begin
         run_cmd($urandom_range(0, 1), 8'($urandom), $urandom_range(0, 4),
                 $urandom_range(0, 5), $urandom_range(0, 12));
      end

      pt_byte[0] = 8'h08; pt_byte[1] = 8'h05; pt_byte[2] = 8'hFB;
      pt_err[0]  = 2'b00; pt_err[1]  = 2'b10; pt_err[2]  = 2'b00;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         pt_cyc[i] = cyc + 1;
         pulse_rx(pt_byte[i], pt_err[i]);
      end
      repeat (2) @(negedge CLK);
      check_val("pass_count", rx_bytes.size(), rx_rd + 3);
      for (int i = 0; i < 3; i++) begin
         if (rx_rd < rx_bytes.size()) begin
            check_val("pass_byte", rx_bytes[rx_rd], pt_byte[i]);
            check_val("pass_cycle", rx_cycs[rx_rd], pt_cyc[i]);
            rx_rd++;
         end
      end

      run_cmd(1, 8'hF4, 4, 0, 3);    // four 0xFE answers: retries exhausted

      // Reset while waiting for the acknowledge.
      g0 = grant_cnt;
      @(negedge CLK);
      REQ0_VALID = 1'b1; REQ0_BYTE = 8'h3C;
      wait_grant(g0, 0);
      REQ0_VALID = 1'b0;
      repeat (2) @(negedge CLK);
      pulse_sent();
      repeat (3) @(negedge CLK);
      d0 = done_cnt; s0 = send_cnt;
      RESET = 1'b1;
      @(negedge CLK);
      RESET = 1'b0;
      model_last = 1;
      check_val("rr_busy", BUSY, 0);
      check_val("rr_tx_byte", BYTE_TO_SEND, 8'hFF);
      check_val("rr_status", DONE_STATUS, 2'b00);
      check_val("rr_rx_byte", RX_PASS_BYTE, 8'h00);
      repeat (ACK_TO + 10) @(negedge CLK);
      check_val("rr_no_done", done_cnt, d0);
      check_val("rr_no_send", send_cnt, s0);
      run_cmd(1, 8'hE6, 1, 0, 2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
